// File: rtl/rvv_vd_collector_if.sv
// Lane-result and register-file write bundle between the vector ALU and the
// destination collector. The master drives lane chunks and wr_ready; the
// slave (collector) drives the assembled image and status.
interface rvv_vd_collector_if #(
  parameter int unsigned VLEN     = 128,
  parameter int unsigned NB_LANES = 1
);
  localparam int unsigned L = 1 << NB_LANES;

  logic              start;
  logic [2:0]        vsew;
  logic [VLEN-1:0]   vd_old;
  logic [64*L-1:0]   lane_vd;
  logic [10*L-1:0]   lane_idx;
  logic [L-1:0]      lane_valid;
  logic              lane_done;
  logic [VLEN-1:0]   vd_out;
  logic              wr_valid;
  logic              wr_ready;
  logic              busy;
  logic [9:0]        chunk_count;
  logic              err;

  modport master (
    output start, vsew, vd_old, lane_vd, lane_idx, lane_valid, lane_done, wr_ready,
    input  vd_out, wr_valid, busy, chunk_count, err
  );

  modport slave (
    input  start, vsew, vd_old, lane_vd, lane_idx, lane_valid, lane_done, wr_ready,
    output vd_out, wr_valid, busy, chunk_count, err
  );
endinterface

// File: rtl/rvv_vd_collector.sv
// Collects per-lane result chunks into a VLEN-bit destination image, starting
// from the old destination value, and hands the image to the register file
// through a valid/ready write. Bits no chunk touches keep their old value.
module rvv_vd_collector #(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 3,
  parameter int unsigned NB_LANES   = 1
) (
  input logic               clk,
  input logic               reset,
  rvv_vd_collector_if.slave bus
);
  localparam int unsigned L = 1 << NB_LANES;

  typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

  state_e          r_state;
  logic [VLEN-1:0] r_buf;
  logic [VLEN-1:0] r_vd_out;
  logic            r_wr_valid;
  logic            r_busy;
  logic [9:0]      r_cnt;
  logic            r_err;
  logic [2:0]      r_vsew;

  logic [3:0]      w_sew_log;
  logic [3:0]      w_chunk_log;
  logic [10:0]     w_width;
  logic [VLEN-1:0] w_base_mask;
  logic [VLEN-1:0] w_buf_next;
  logic            w_oor;
  logic [NB_LANES:0] w_accept;
  logic [10:0]     w_cnt_sum;
  logic [9:0]      w_cnt_next;

  // Chunk width: element width capped at the lane chunk width.
  always_comb begin
    w_sew_log   = {1'b0, r_vsew} + 4'd3;
    w_chunk_log = (w_sew_log < 4'(LANE_WIDTH)) ? w_sew_log : 4'(LANE_WIDTH);
    w_width     = 11'd1 << w_chunk_log;
  end

  // Merge this cycle's in-range chunks; later (higher) lanes overwrite earlier ones.
  always_comb begin
    logic [9:0]      w_idx;
    logic [VLEN-1:0] w_data;
    w_base_mask = '0;
    w_buf_next  = r_buf;
    w_oor       = 1'b0;
    w_accept    = '0;
    w_idx       = '0;
    w_data      = '0;
    for (int j = 0; j < int'(VLEN); j++) begin
      w_base_mask[j] = (j < int'(w_width));
    end
    for (int l = 0; l < int'(L); l++) begin
      w_idx = bus.lane_idx[10*l +: 10];
      if (bus.lane_valid[l]) begin
        if ({1'b0, w_idx} + w_width <= 11'(VLEN)) begin
          w_data     = VLEN'(bus.lane_vd[64*l +: 64]) & w_base_mask;
          w_buf_next = (w_buf_next & ~(w_base_mask << w_idx)) | (w_data << w_idx);
          w_accept   = w_accept + 1'b1;
        end else begin
          w_oor = 1'b1;
        end
      end
    end
  end

  // Saturating chunk counter.
  always_comb begin
    w_cnt_sum  = {1'b0, r_cnt} + 11'(w_accept);
    w_cnt_next = (w_cnt_sum > 11'd1023) ? 10'd1023 : w_cnt_sum[9:0];
  end

  // Control FSM with registered outputs; reset discards any partial image.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_buf      <= '0;
      r_vd_out   <= '0;
      r_wr_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_vsew     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_buf   <= bus.vd_old;
            r_vsew  <= bus.vsew;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StCollect;
          end
        end
        StCollect: begin
          r_buf <= w_buf_next;
          r_cnt <= w_cnt_next;
          if (w_oor) r_err <= 1'b1;
          if (bus.lane_done) begin
            r_vd_out   <= w_buf_next;
            r_wr_valid <= 1'b1;
            r_state    <= StWrite;
          end
        end
        StWrite: begin
          if (bus.wr_ready) begin
            r_wr_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.vd_out      = r_vd_out;
  assign bus.wr_valid    = r_wr_valid;
  assign bus.busy        = r_busy;
  assign bus.chunk_count = r_cnt;
  assign bus.err         = r_err;
endmodule
